wash_cycle_ctrl: RTL and testbench
==================================

Name: wash_cycle_ctrl

Overview:
- Top-level sequencer for the washing machine.
- Owns the single shared `timer` instance and drives it through each wash phase: FILL, WASH, RINSE and SPIN, with an optional second WASH/RINSE pass.
- For each phase it programs the timer's `clk_freq`/`timer_period`, restarts the timer, and advances when the timer reports `done`.
- Handles coin start, double-wash selection and lid-open pause during spin.

Parameters:
- CLK_FREQ, 16'd5, clock cycles per second; driven unchanged on `tmr_freq`.
- FILL_T, 16'd2, fill duration in seconds.
- WASH_T, 16'd5, wash duration in seconds.
- RINSE_T, 16'd2, rinse duration in seconds.
- SPIN_T, 16'd1, spin duration in seconds.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- coin_in  input  1  start request; honoured only in IDLE.
- double_wash  input  1  sampled with `coin_in`; selects a second WASH+RINSE pass.
- lid_open  input  1  lid sensor; pauses the timer during SPIN only.
- tmr_done  input  1  `done` from the shared timer.
- tmr_enable  output  1  timer `enable`.
- tmr_clear  output  1  timer restart pulse, active-high, one cycle.
- tmr_freq  output  16  timer `clk_freq`.
- tmr_period  output  16  timer `timer_period`, in seconds.
- state  output  3  current phase: IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4.
- door_lock  output  1  high whenever state != IDLE.
- wash_done  output  1  one-cycle pulse on SPIN->IDLE.

Behaviour:
- Reset (reset=0), asynchronous:
  - state=IDLE, tmr_clear=0, tmr_period=0, wash_done=0.
  - Internal second-pass flag and double-wash latch cleared.
  - Combinational outputs follow (tmr_enable=0, door_lock=0).
  - Holds while reset low; a mid-operation reset aborts immediately with no wash_done.
- tmr_freq is constant CLK_FREQ in every state, including during reset.
- tmr_enable is a combinational decode: 1 when state != IDLE and not (state==SPIN and lid_open).
- Phase entry (registered, on the transition edge):
  - state <= next.
  - tmr_period <= FILL_T / WASH_T / RINSE_T / SPIN_T for FILL / WASH / RINSE / SPIN.
  - tmr_clear <= 1.
  - On the following edge tmr_clear <= 0, so the pulse is exactly 1 cycle.
- tmr_done is ignored in any cycle where tmr_clear=1 (stale done from the previous phase).
- tmr_done is ignored while tmr_enable=0.
- Transitions:
  - IDLE: coin_in=1 -> FILL; latch double_wash and clear the second-pass flag.
  - FILL: qualified tmr_done -> WASH.
  - WASH: qualified tmr_done -> RINSE.
  - RINSE: qualified tmr_done -> WASH if double_wash latched and second-pass flag=0 (set the flag); otherwise -> SPIN.
  - SPIN: qualified tmr_done -> IDLE; wash_done <= 1 for one cycle; tmr_period <= 0.
- coin_in outside IDLE is ignored, as is a double_wash change after the start.
- lid_open outside SPIN is ignored (door locked).
- SPIN with lid_open=1: state holds, tmr_enable=0, tmr_clear not reasserted; the timer keeps its count and resumes when the lid closes.
- Simultaneous coin_in and SPIN->IDLE in the same cycle: coin ignored; a new cycle needs coin_in while state=IDLE.
- Unused state encodings 5-7 -> IDLE on the next edge, with all registered outputs set to their reset values.
- Latency: exactly 1 clock from coin_in or a qualified tmr_done to the new state value.

Test Plan:
1. Reset: drive reset=0 mid-clock with garbage inputs.
   - Immediately: state=0, tmr_enable=0, tmr_clear=0, door_lock=0, wash_done=0, tmr_freq=5.
2. Single wash (stub timer pulses tmr_done 10 cycles after each clear):
   - coin_in=1 for 1 cycle -> next edge state=1, tmr_period=2, tmr_clear high exactly 1 cycle.
   - Phases then run 1->2 (period 5) ->3 (period 2) ->4 (period 1) ->0.
   - wash_done high exactly 1 cycle; door_lock high throughout the run.
3. Double wash: coin_in=1 with double_wash=1.
   - State sequence 1,2,3,2,3,4,0.
   - Dropping double_wash mid-run does not change the sequence.
4. Lid pause: lid_open=1 for 20 cycles in SPIN.
   - tmr_enable=0 for those 20 cycles and state stays 4.
   - A forced tmr_done pulse during the pause is ignored.
   - After the lid closes, the next tmr_done -> state 0 with wash_done.
5. Stale/ignored inputs:
   - tmr_done held high through a phase entry -> no skip; the controller waits one full clear cycle before accepting it.
   - coin_in pulsed in WASH -> no effect.
6. Mid-operation reset:
   - reset=0 during RINSE -> state=0 asynchronously, no wash_done.
   - After release, coin_in restarts at FILL.

Source files
------------

// File: rtl/wash_cycle_ctrl.sv
// Washing-machine phase sequencer: FILL -> WASH -> RINSE (-> WASH -> RINSE) -> SPIN.
// It drives the one shared timer and moves to the next phase when the timer reports done.
module wash_cycle_ctrl #(
    parameter logic [15:0] CLK_FREQ = 16'd5,
    parameter logic [15:0] FILL_T   = 16'd2,
    parameter logic [15:0] WASH_T   = 16'd5,
    parameter logic [15:0] RINSE_T  = 16'd2,
    parameter logic [15:0] SPIN_T   = 16'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        coin_in,
    input  logic        double_wash,
    input  logic        lid_open,
    input  logic        tmr_done,
    output logic        tmr_enable,
    output logic        tmr_clear,
    output logic [15:0] tmr_freq,
    output logic [15:0] tmr_period,
    output logic [2:0]  state,
    output logic        door_lock,
    output logic        wash_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WASH  = 3'd2,
        S_RINSE = 3'd3,
        S_SPIN  = 3'd4
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] period_d;
    logic        clear_d;
    logic        wash_done_d;
    logic        dbl_q;
    logic        dbl_d;
    logic        second_q;
    logic        second_d;
    logic        done_ok;

    assign tmr_freq   = CLK_FREQ;
    assign state      = state_q;
    assign door_lock  = (state_q != S_IDLE);
    assign tmr_enable = (state_q != S_IDLE) && !((state_q == S_SPIN) && lid_open);

    // A done seen during the restart cycle belongs to the previous phase.
    assign done_ok = tmr_done && tmr_enable && !tmr_clear;

    always_comb begin
        state_d     = state_q;
        period_d    = tmr_period;
        clear_d     = 1'b0;
        wash_done_d = 1'b0;
        dbl_d       = dbl_q;
        second_d    = second_q;
        case (state_q)
            S_IDLE: begin
                if (coin_in) begin
                    state_d  = S_FILL;
                    period_d = FILL_T;
                    clear_d  = 1'b1;
                    dbl_d    = double_wash;
                    second_d = 1'b0;
                end
            end
            S_FILL: begin
                if (done_ok) begin
                    state_d  = S_WASH;
                    period_d = WASH_T;
                    clear_d  = 1'b1;
                end
            end
            S_WASH: begin
                if (done_ok) begin
                    state_d  = S_RINSE;
                    period_d = RINSE_T;
                    clear_d  = 1'b1;
                end
            end
            S_RINSE: begin
                if (done_ok) begin
                    clear_d = 1'b1;
                    if (dbl_q && !second_q) begin
                        state_d  = S_WASH;
                        period_d = WASH_T;
                        second_d = 1'b1;
                    end else begin
                        state_d  = S_SPIN;
                        period_d = SPIN_T;
                    end
                end
            end
            S_SPIN: begin
                if (done_ok) begin
                    state_d     = S_IDLE;
                    period_d    = 16'd0;
                    wash_done_d = 1'b1;
                end
            end
            default: begin
                // Illegal encodings recover to the reset condition.
                state_d  = S_IDLE;
                period_d = 16'd0;
                dbl_d    = 1'b0;
                second_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            tmr_period <= 16'd0;
            tmr_clear  <= 1'b0;
            wash_done  <= 1'b0;
            dbl_q      <= 1'b0;
            second_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_period <= period_d;
            tmr_clear  <= clear_d;
            wash_done  <= wash_done_d;
            dbl_q      <= dbl_d;
            second_q   <= second_d;
        end
    end

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Bench for wash_cycle_ctrl: stub timer, phase-sequence scoreboard with dwell-time model,
// directed corner cases plus randomized wash runs.
`timescale 1ns/1ps
module tb_wash_cycle_ctrl;

    localparam int          L      = 10;    // stub timer: done this many enabled cycles after clear
    localparam logic [15:0] FREQ   = 16'd5;
    localparam logic [15:0] FILL_T = 16'd2;
    localparam logic [15:0] WASH_T = 16'd5;
    localparam logic [15:0] RINS_T = 16'd2;
    localparam logic [15:0] SPIN_T = 16'd1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        coin_in = 1'b0;
    logic        double_wash = 1'b0;
    logic        lid_open = 1'b0;
    logic        force_done = 1'b0;
    logic        tmr_done;
    logic        tmr_enable;
    logic        tmr_clear;
    logic [15:0] tmr_freq;
    logic [15:0] tmr_period;
    logic [2:0]  state;
    logic        door_lock;
    logic        wash_done;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [2:0]  exp_q[$];
    logic        mon_on = 1'b0;
    logic        dwell_chk = 1'b1;
    logic [2:0]  prev_state = 3'd0;
    logic [2:0]  mon_e;
    int          cyc = 0;
    int          entry_cyc = 0;
    int          pause_cyc = 0;
    int          last_dwell = 0;
    int          wd_count = 0;
    int          tmr_cnt = L;

    wash_cycle_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .coin_in     (coin_in),
        .double_wash (double_wash),
        .lid_open    (lid_open),
        .tmr_done    (tmr_done),
        .tmr_enable  (tmr_enable),
        .tmr_clear   (tmr_clear),
        .tmr_freq    (tmr_freq),
        .tmr_period  (tmr_period),
        .state       (state),
        .door_lock   (door_lock),
        .wash_done   (wash_done)
    );

    // ---------------- clock / stub timer ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tmr_clear === 1'b1) tmr_cnt <= 0;
        else if (tmr_enable === 1'b1 && tmr_cnt < L) tmr_cnt <= tmr_cnt + 1;
    end
    assign tmr_done = (tmr_cnt == L) || force_done;

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] period_of(input logic [2:0] ph);
        case (ph)
            3'd1:    return FILL_T;
            3'd2:    return WASH_T;
            3'd3:    return RINS_T;
            3'd4:    return SPIN_T;
            default: return 16'd0;
        endcase
    endfunction

    task automatic push_seq(input logic dbl);
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd3);
        if (dbl) begin
            exp_q.push_back(3'd2);
            exp_q.push_back(3'd3);
        end
        exp_q.push_back(3'd4);
        exp_q.push_back(3'd0);
    endtask

    // Scoreboard: each phase entry must match the expected sequence; each phase must last
    // one restart cycle + L timer cycles + one decision cycle, plus any lid-pause cycles.
    always @(negedge clk) begin
        if (!mon_on || reset !== 1'b1) begin
            prev_state = 3'd0;
            pause_cyc  = 0;
        end else begin
            cyc++;
            check("door_lock", 32'(door_lock), 32'(state != 3'd0));
            check("tmr_enable", 32'(tmr_enable), 32'((state != 3'd0) && !(state == 3'd4 && lid_open)));
            check("tmr_freq", 32'(tmr_freq), 32'(FREQ));
            if (wash_done === 1'b1) wd_count++;
            if (state !== prev_state) begin
                if (prev_state != 3'd0) begin
                    last_dwell = cyc - entry_cyc;
                    if (dwell_chk) check("dwell", 32'(last_dwell), 32'(L + 2 + pause_cyc));
                end
                if (exp_q.size() == 0) begin
                    check("unexp_entry", 32'(state), 32'(prev_state));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("state_seq", 32'(state), 32'(mon_e));
                    check("period", 32'(tmr_period), 32'(period_of(mon_e)));
                    check("clear_entry", 32'(tmr_clear), 32'(mon_e != 3'd0));
                    check("wash_done_entry", 32'(wash_done), 32'(mon_e == 3'd0));
                end
                entry_cyc  = cyc;
                pause_cyc  = 0;
                prev_state = state;
            end else begin
                check("clear_hold", 32'(tmr_clear), 32'd0);
                check("wash_done_hold", 32'(wash_done), 32'd0);
                if (state == 3'd4 && lid_open) pause_cyc++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        int n = 0;
        while (state !== s && n < budget) begin
            tick();
            n++;
        end
        check("wait_state", 32'(state), 32'(s));
    endtask

    task automatic start_coin(input logic dbl);
        double_wash = dbl;
        coin_in = 1'b1;
        tick();
        coin_in = 1'b0;
        check("coin_latency", 32'(state), 32'd1);
    endtask

    task automatic finish_run(input int wd0);
        wait_state(3'd0, 400);
        tick();
        check("wash_done_count", 32'(wd_count), 32'(wd0 + 1));
        check("exp_drained", 32'(exp_q.size()), 32'd0);
        double_wash = 1'b0;
    endtask

    task automatic run_wash(input logic dbl, input logic flip, input int pause_len, input logic stray);
        int wd0 = wd_count;
        push_seq(dbl);
        start_coin(dbl);
        if (flip) begin
            tick();
            tick();
            double_wash = ~dbl;
        end
        if (stray) begin
            wait_state(3'd2, 100);
            tick();
            tick();
            coin_in  = 1'b1;
            lid_open = 1'b1;
            tick();
            coin_in  = 1'b0;
            lid_open = 1'b0;
        end
        if (pause_len > 0) begin
            wait_state(3'd4, 400);
            tick();
            tick();
            tick();
            lid_open = 1'b1;
            for (int i = 0; i < pause_len; i++) begin
                force_done = (i == pause_len / 2);
                tick();
                check("pause_state", 32'(state), 32'd4);
            end
            force_done = 1'b0;
            lid_open   = 1'b0;
        end
        finish_run(wd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int wd0;
        // Reset asserted mid-clock with garbage on the inputs.
        coin_in     = 1'($urandom_range(0, 1));
        double_wash = 1'($urandom_range(0, 1));
        lid_open    = 1'($urandom_range(0, 1));
        force_done  = 1'($urandom_range(0, 1));
        #13;
        reset = 1'b0;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_enable", 32'(tmr_enable), 32'd0);
        check("rst_clear", 32'(tmr_clear), 32'd0);
        check("rst_door_lock", 32'(door_lock), 32'd0);
        check("rst_wash_done", 32'(wash_done), 32'd0);
        check("rst_freq", 32'(tmr_freq), 32'(FREQ));
        check("rst_period", 32'(tmr_period), 32'd0);
        coin_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_hold_state", 32'(state), 32'd0);
        end
        coin_in = 1'b0; double_wash = 1'b0; lid_open = 1'b0; force_done = 1'b0;
        reset  = 1'b1;
        mon_on = 1'b1;
        tick();
        tick();

        // Directed: single, double with mid-run flip, lid pause of 20 cycles.
        run_wash(1'b0, 1'b0, 0, 1'b0);
        run_wash(1'b1, 1'b1, 0, 1'b0);
        run_wash(1'b0, 1'b0, 20, 1'b0);
        run_wash(1'b0, 1'b1, 0, 1'b1);

        // Held done across a phase entry: RINSE must still take its restart cycle.
        wd0 = wd_count;
        push_seq(1'b0);
        start_coin(1'b0);
        wait_state(3'd2, 100);
        tick(); tick(); tick();
        dwell_chk  = 1'b0;
        force_done = 1'b1;
        tick(); tick(); tick();
        force_done = 1'b0;
        tick();
        check("held_done_rinse_dwell", 32'(last_dwell), 32'd2);
        check("held_done_state", 32'(state), 32'd4);
        dwell_chk = 1'b1;
        finish_run(wd0);

        // Coin held across SPIN->IDLE is ignored.
        wd0 = wd_count;
        push_seq(1'b0);
        start_coin(1'b0);
        wait_state(3'd4, 400);
        tick();
        coin_in = 1'b1;
        for (int n = 0; n < 100 && state !== 3'd0; n++) tick();
        coin_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("coin_at_end", 32'(state), 32'd0);
        end
        check("coin_at_end_wd", 32'(wd_count), 32'(wd0 + 1));
        check("coin_at_end_drain", 32'(exp_q.size()), 32'd0);

        // Mid-operation reset during RINSE.
        wd0 = wd_count;
        push_seq(1'b0);
        start_coin(1'b0);
        wait_state(3'd3, 400);
        tick();
        #1;
        reset = 1'b0;
        #1;
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_enable", 32'(tmr_enable), 32'd0);
        check("midrst_door", 32'(door_lock), 32'd0);
        check("midrst_clear", 32'(tmr_clear), 32'd0);
        check("midrst_period", 32'(tmr_period), 32'd0);
        check("midrst_wash_done", 32'(wash_done), 32'd0);
        exp_q.delete();
        tick(); tick();
        reset = 1'b1;
        tick();
        check("midrst_no_done", 32'(wd_count), 32'(wd0));
        run_wash(1'b0, 1'b0, 0, 1'b0);

        // Randomized runs.
        for (int r = 0; r < 6; r++) begin
            logic dbl;
            logic flip;
            logic stray;
            int   pl;
            dbl   = 1'($urandom_range(0, 1));
            flip  = 1'($urandom_range(0, 1));
            stray = 1'($urandom_range(0, 1));
            pl    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 15)) : 0;
            run_wash(dbl, flip, pl, stray);
            repeat ($urandom_range(1, 5)) tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
